// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALU/mux codes,
// FSM states and the opcode classifier used by the controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OpcR    = 6'b000000;
    localparam logic [5:0] OpcLw   = 6'b100011;
    localparam logic [5:0] OpcSw   = 6'b101011;
    localparam logic [5:0] OpcAddi = 6'b001000;
    localparam logic [5:0] OpcAndi = 6'b001100;
    localparam logic [5:0] OpcOri  = 6'b001101;
    localparam logic [5:0] OpcBeq  = 6'b000100;
    localparam logic [5:0] OpcBne  = 6'b000101;
    localparam logic [5:0] OpcJ    = 6'b000010;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluOr    = 3'b110;

    localparam logic [1:0] SrcBRt    = 2'b00;
    localparam logic [1:0] SrcB4     = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
        StRwb, StImmEx, StImmWb, StBranch, StJump, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsR, ClsLw, ClsSw, ClsAddi, ClsAndi, ClsOri, ClsBeq, ClsBne, ClsJ, ClsIllegal
    } op_class_e;

    function automatic op_class_e decode_opcode(input logic [5:0] opc);
        op_class_e cls;
        case (opc)
            OpcR:    cls = ClsR;
            OpcLw:   cls = ClsLw;
            OpcSw:   cls = ClsSw;
            OpcAddi: cls = ClsAddi;
            OpcAndi: cls = ClsAndi;
            OpcOri:  cls = ClsOri;
            OpcBeq:  cls = ClsBeq;
            OpcBne:  cls = ClsBne;
            OpcJ:    cls = ClsJ;
            default: cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/ALU status in, datapath enables and selects out.
interface multicycle_controller_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;

    logic                pcWrite;
    logic                iorD;
    logic                memRead;
    logic                memWrite;
    logic                irWrite;
    logic                memtoReg;
    logic                regDst;
    logic                regWrite;
    logic                aluSrcA;
    logic [1:0]          aluSrcB;
    logic [1:0]          pcSrc;
    logic [ALUOP_W-1:0]  aluOp;
    logic                fault;

    modport master (
        input  opcode, zero, mem_ready,
        output pcWrite, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite,
               aluSrcA, aluSrcB, pcSrc, aluOp, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcWrite, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite,
               aluSrcA, aluSrcB, pcSrc, aluOp, fault
    );
endinterface

// File: rtl/mem_watchdog.sv
// Counts consecutive memory wait cycles; expire_o flags the wait cycle that reaches TIMEOUT.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned CntW   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clear_i,
    output logic expire_o
);
    logic [CntW-1:0] count_q, count_d, count_inc;

    always_comb begin
        count_inc = count_q + CntW'(1);
        expire_o  = inc_i && (count_inc == CntW'(TIMEOUT));
        count_d   = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main control FSM: sequences each instruction through its states and
// drives datapath enables; illegal opcodes and memory timeouts park it in HALT with fault.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter bit          MEM_WAIT = 1'b1,
    parameter int unsigned TIMEOUT  = 16
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);
    state_e              state_q, state_d;
    op_class_e           class_q, class_d;
    logic                fault_q, fault_d;
    logic                ready;
    logic                wd_inc, wd_clear, wd_expire;
    logic [OPCODE_W-1:0] opc;

    assign opc      = bus.opcode;
    assign ready    = MEM_WAIT ? bus.mem_ready : 1'b1;
    assign wd_inc   = MEM_WAIT && !bus.mem_ready &&
                      (state_q == StFetch || state_q == StMemRd || state_q == StMemWr);
    assign wd_clear = (state_d != state_q);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (wd_inc),
        .clear_i  (wd_clear),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        fault_d      = fault_q;
        bus.pcWrite  = 1'b0;
        bus.iorD     = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.irWrite  = 1'b0;
        bus.memtoReg = 1'b0;
        bus.regDst   = 1'b0;
        bus.regWrite = 1'b0;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = SrcBRt;
        bus.pcSrc    = PcSrcAlu;
        bus.aluOp    = ALUOP_W'(AluAdd);
        bus.fault    = fault_q & ~rst;

        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    if (wd_expire) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        bus.memRead = 1'b1;
                        bus.aluSrcB = SrcB4;
                        if (ready) begin
                            bus.irWrite = 1'b1;
                            bus.pcWrite = 1'b1;
                            state_d     = StDecode;
                        end
                    end
                end
                StDecode: begin
                    // ALU precomputes the branch target while the opcode is classified
                    bus.aluSrcB = SrcBImmSh;
                    class_d     = decode_opcode(6'(opc));
                    case (class_d)
                        ClsR:                   state_d = StExec;
                        ClsLw, ClsSw:           state_d = StMemAdr;
                        ClsAddi, ClsAndi, ClsOri: state_d = StImmEx;
                        ClsBeq, ClsBne:         state_d = StBranch;
                        ClsJ:                   state_d = StJump;
                        default: begin
                            state_d = StHalt;
                            fault_d = 1'b1;
                        end
                    endcase
                end
                StMemAdr: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = SrcBImm;
                    state_d     = (class_q == ClsLw) ? StMemRd : StMemWr;
                end
                StMemRd: begin
                    if (wd_expire) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        bus.memRead = 1'b1;
                        bus.iorD    = 1'b1;
                        if (ready) state_d = StMemWb;
                    end
                end
                StMemWb: begin
                    bus.regWrite = 1'b1;
                    bus.memtoReg = 1'b1;
                    state_d      = StFetch;
                end
                StMemWr: begin
                    if (wd_expire) begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end else begin
                        bus.memWrite = 1'b1;
                        bus.iorD     = 1'b1;
                        if (ready) state_d = StFetch;
                    end
                end
                StExec: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluOp   = ALUOP_W'(AluFunct);
                    state_d     = StRwb;
                end
                StRwb: begin
                    bus.regWrite = 1'b1;
                    bus.regDst   = 1'b1;
                    state_d      = StFetch;
                end
                StImmEx: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = SrcBImm;
                    case (class_q)
                        ClsAndi: bus.aluOp = ALUOP_W'(AluAnd);
                        ClsOri:  bus.aluOp = ALUOP_W'(AluOr);
                        default: bus.aluOp = ALUOP_W'(AluAdd);
                    endcase
                    state_d = StImmWb;
                end
                StImmWb: begin
                    bus.regWrite = 1'b1;
                    state_d      = StFetch;
                end
                StBranch: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluOp   = ALUOP_W'(AluSub);
                    bus.pcSrc   = PcSrcAluOut;
                    bus.pcWrite = (class_q == ClsBeq) ? bus.zero : ~bus.zero;
                    state_d     = StFetch;
                end
                StJump: begin
                    bus.pcSrc   = PcSrcJump;
                    bus.pcWrite = 1'b1;
                    state_d     = StFetch;
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StHalt;
                    fault_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            class_q <= ClsR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            fault_q <= fault_d;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vectors for the multi-cycle controller; each cycle drives inputs and
// compares the full output bundle against a hand-derived pattern.
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_controller_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

    multicycle_controller #(
        .OPCODE_W (6),
        .ALUOP_W  (3),
        .MEM_WAIT (1'b1),
        .TIMEOUT  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [16:0] exp;
    } vec_t;

    // {pcWrite,iorD,memRead,memWrite,irWrite,memtoReg,regDst,regWrite,aluSrcA,aluSrcB,pcSrc,aluOp,fault}
    function automatic logic [16:0] pat(input logic pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa,
                                        input logic [1:0] asb, psrc, input logic [2:0] aop,
                                        input logic flt);
        return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, psrc, aop, flt};
    endfunction

    localparam logic [16:0] FetchR  = pat(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    localparam logic [16:0] FetchW  = pat(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
    localparam logic [16:0] Dec     = pat(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0);
    localparam logic [16:0] MemAdr  = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
    localparam logic [16:0] MemRd   = pat(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    localparam logic [16:0] MemWb   = pat(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    localparam logic [16:0] MemWr   = pat(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    localparam logic [16:0] Exec    = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
    localparam logic [16:0] Rwb     = pat(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    localparam logic [16:0] ImmAdd  = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
    localparam logic [16:0] ImmAnd  = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b100, 0);
    localparam logic [16:0] ImmOr   = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b110, 0);
    localparam logic [16:0] ImmWb   = pat(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
    localparam logic [16:0] BrTaken = pat(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    localparam logic [16:0] BrNot   = pat(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
    localparam logic [16:0] Jump    = pat(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
    localparam logic [16:0] Halt    = pat(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
    localparam logic [16:0] Quiet   = 17'h0;
    localparam logic [5:0]  OpcBad  = 6'b111111;

    function automatic vec_t mk(input logic r, rdy, z, input logic [5:0] op,
                                input logic [16:0] exp);
        return '{rst: r, rdy: rdy, z: z, op: op, exp: exp};
    endfunction

    function automatic logic [16:0] outs();
        return {bus.pcWrite, bus.iorD, bus.memRead, bus.memWrite, bus.irWrite, bus.memtoReg,
                bus.regDst, bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.aluOp,
                bus.fault};
    endfunction

    // Drive one cycle's inputs just after the edge and let the outputs settle mid-cycle.
    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.mem_ready = v.rdy;
        bus.zero      = v.z;
        bus.opcode    = v.op;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t q[$];
        q.push_back(mk(1, 1, 0, OpcLw, Quiet));
        q.push_back(mk(1, 0, 1, OpcBad, Quiet));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_lw();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcLw, FetchR));
        q.push_back(mk(0, 1, 0, OpcLw, Dec));
        q.push_back(mk(0, 1, 0, OpcBad, MemAdr));  // opcode outside DECODE is ignored
        q.push_back(mk(0, 1, 0, OpcSw, MemRd));
        q.push_back(mk(0, 1, 0, OpcR, MemWb));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL lw cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_sw_wait();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcSw, FetchR));
        q.push_back(mk(0, 1, 0, OpcSw, Dec));
        q.push_back(mk(0, 1, 0, OpcSw, MemAdr));
        q.push_back(mk(0, 0, 0, OpcSw, MemWr));
        q.push_back(mk(0, 0, 0, OpcSw, MemWr));
        q.push_back(mk(0, 0, 0, OpcSw, MemWr));
        q.push_back(mk(0, 1, 0, OpcSw, MemWr));
        q.push_back(mk(0, 0, 0, OpcSw, FetchW));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL sw_wait cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcBeq, FetchR));
        q.push_back(mk(0, 1, 0, OpcBeq, Dec));
        q.push_back(mk(0, 1, 1, OpcBeq, BrTaken));
        q.push_back(mk(0, 1, 1, OpcBne, FetchR));
        q.push_back(mk(0, 1, 1, OpcBne, Dec));
        q.push_back(mk(0, 1, 1, OpcBne, BrNot));
        q.push_back(mk(0, 1, 0, OpcBne, FetchR));
        q.push_back(mk(0, 1, 0, OpcBne, Dec));
        q.push_back(mk(0, 1, 0, OpcBeq, BrTaken));  // latched BNE, not live BEQ
        q.push_back(mk(0, 1, 0, OpcBeq, FetchR));
        q.push_back(mk(0, 1, 0, OpcBeq, Dec));
        q.push_back(mk(0, 1, 0, OpcBeq, BrNot));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL branch cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcR, FetchR));
        q.push_back(mk(0, 1, 0, OpcR, Dec));
        q.push_back(mk(0, 1, 0, OpcR, Exec));
        q.push_back(mk(0, 1, 0, OpcR, Rwb));
        q.push_back(mk(0, 1, 0, OpcAddi, FetchR));
        q.push_back(mk(0, 1, 0, OpcAddi, Dec));
        q.push_back(mk(0, 1, 0, OpcOri, ImmAdd));
        q.push_back(mk(0, 1, 0, OpcAddi, ImmWb));
        q.push_back(mk(0, 1, 0, OpcAndi, FetchR));
        q.push_back(mk(0, 1, 0, OpcAndi, Dec));
        q.push_back(mk(0, 1, 0, OpcAndi, ImmAnd));
        q.push_back(mk(0, 1, 0, OpcAndi, ImmWb));
        q.push_back(mk(0, 1, 0, OpcOri, FetchR));
        q.push_back(mk(0, 1, 0, OpcOri, Dec));
        q.push_back(mk(0, 1, 0, OpcAndi, ImmOr));
        q.push_back(mk(0, 1, 0, OpcOri, ImmWb));
        q.push_back(mk(0, 1, 0, OpcJ, FetchR));
        q.push_back(mk(0, 1, 0, OpcJ, Dec));
        q.push_back(mk(0, 1, 0, OpcJ, Jump));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL alu_ops cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcBad, FetchR));
        q.push_back(mk(0, 1, 0, OpcBad, Dec));
        q.push_back(mk(0, 1, 0, OpcLw, Halt));
        q.push_back(mk(0, 0, 1, OpcR, Halt));
        q.push_back(mk(0, 1, 0, OpcJ, Halt));
        q.push_back(mk(1, 1, 0, OpcR, Quiet));
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(1, 0, 0, OpcR, Quiet));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        vec_t q[$];
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, Quiet));   // fourth wait cycle: expire, no strobe
        q.push_back(mk(0, 1, 0, OpcR, Halt));
        q.push_back(mk(0, 1, 0, OpcLw, Halt));
        q.push_back(mk(1, 0, 0, OpcR, Quiet));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        vec_t q[$];
        q.push_back(mk(0, 1, 0, OpcSw, FetchR));
        q.push_back(mk(0, 1, 0, OpcSw, Dec));
        q.push_back(mk(0, 1, 0, OpcSw, MemAdr));
        q.push_back(mk(0, 0, 0, OpcSw, MemWr));
        q.push_back(mk(0, 0, 0, OpcSw, MemWr));
        q.push_back(mk(1, 0, 0, OpcSw, Quiet));  // memWrite drops in the reset cycle
        q.push_back(mk(0, 0, 0, OpcSw, FetchW));
        q.push_back(mk(0, 0, 0, OpcSw, FetchW));
        q.push_back(mk(1, 0, 0, OpcSw, Quiet));  // reset while staying in FETCH
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, FetchW));
        q.push_back(mk(0, 0, 0, OpcR, Quiet));
        q.push_back(mk(0, 0, 0, OpcR, Halt));
        q.push_back(mk(1, 1, 0, OpcR, Quiet));
        q.push_back(mk(0, 1, 0, OpcJ, FetchR));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if (outs() !== q[i].exp) begin
                errors++;
                $display("FAIL reset_mid_wait cyc %0d got %h want %h", i, outs(), q[i].exp);
            end
            tick();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.opcode    = OpcR;
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_alu_ops();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit got %0d checks want completion", checks);
        $fatal(1, "time limit");
    end
endmodule
